// File: rtl/reg_write_bank.sv
// reg_write_bank: captures the bus into the register selected by write_en, runs inc/clr
// commands on rp/rc/rr/rn, loads ac from the ALU and issues a registered data-RAM write.
module reg_write_bank #(
   parameter int DW = 16,
   parameter int NW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [4:0]    write_en,
   input  logic [DW-1:0] busOut,
   input  logic [3:0]    inc_en,
   input  logic [3:0]    clr_en,
   input  logic          alu_we,
   input  logic [DW-1:0] alu_out,
   output logic [NW-1:0] ir,
   output logic [NW-1:0] tr,
   output logic [NW-1:0] dr,
   output logic [NW-1:0] rn,
   output logic [NW-1:0] rp,
   output logic [NW-1:0] rc,
   output logic [NW-1:0] rr,
   output logic [NW-1:0] rcol1,
   output logic [NW-1:0] rcol2,
   output logic [DW-1:0] ra,
   output logic [DW-1:0] rb,
   output logic [DW-1:0] ro,
   output logic [DW-1:0] rt,
   output logic [DW-1:0] ac,
   output logic          dram_we,
   output logic [NW-1:0] dram_wdata
);
   typedef struct packed {
      logic [NW-1:0] ir, tr, dr, rn, rp, rc, rr, rcol1, rcol2, dram_wdata;
      logic [DW-1:0] ra, rb, ro, rt, ac;
      logic          dram_we;
   } bank_t;

   localparam logic [NW-1:0] ONE = NW'(1);

   bank_t bank_q, bank_d;
   logic [NW-1:0] lo;

   assign lo = busOut[NW-1:0];

   // counters: clear beats bus write, bus write beats increment
   always_comb begin
      bank_d = bank_q;
      bank_d.ir = (write_en == 5'd1) ? lo : (write_en == 5'd14) ? busOut[DW-1:DW-NW] : bank_q.ir;
      bank_d.tr = (write_en == 5'd2 || write_en == 5'd14) ? lo : bank_q.tr;
      bank_d.dr = (write_en == 5'd3) ? lo : bank_q.dr;
      bank_d.ra = (write_en == 5'd4) ? busOut : bank_q.ra;
      bank_d.rb = (write_en == 5'd5) ? busOut : bank_q.rb;
      bank_d.ro = (write_en == 5'd6) ? busOut : bank_q.ro;
      bank_d.rn = clr_en[3] ? '0 : (write_en == 5'd7) ? lo : inc_en[3] ? bank_q.rn + ONE : bank_q.rn;
      bank_d.rp = clr_en[0] ? '0 : (write_en == 5'd8) ? lo : inc_en[0] ? bank_q.rp + ONE : bank_q.rp;
      bank_d.rc = clr_en[1] ? '0 : (write_en == 5'd9) ? lo : inc_en[1] ? bank_q.rc + ONE : bank_q.rc;
      bank_d.rr = clr_en[2] ? '0 : (write_en == 5'd10) ? lo : inc_en[2] ? bank_q.rr + ONE : bank_q.rr;
      bank_d.rt = (write_en == 5'd11) ? busOut : bank_q.rt;
      bank_d.ac = (write_en == 5'd12) ? busOut :
                  (write_en == 5'd15) ? {busOut[DW-NW-1:0], bank_q.ac[NW-1:0]} :
                  alu_we ? alu_out : bank_q.ac;
      bank_d.rcol1 = (write_en == 5'd16) ? lo : bank_q.rcol1;
      bank_d.rcol2 = (write_en == 5'd17) ? lo : bank_q.rcol2;
      bank_d.dram_we = (write_en == 5'd13);
      bank_d.dram_wdata = (write_en == 5'd13) ? lo : bank_q.dram_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bank_q <= '0;
      else bank_q <= bank_d;
   end

   assign ir = bank_q.ir;
   assign tr = bank_q.tr;
   assign dr = bank_q.dr;
   assign rn = bank_q.rn;
   assign rp = bank_q.rp;
   assign rc = bank_q.rc;
   assign rr = bank_q.rr;
   assign rcol1 = bank_q.rcol1;
   assign rcol2 = bank_q.rcol2;
   assign ra = bank_q.ra;
   assign rb = bank_q.rb;
   assign ro = bank_q.ro;
   assign rt = bank_q.rt;
   assign ac = bank_q.ac;
   assign dram_we = bank_q.dram_we;
   assign dram_wdata = bank_q.dram_wdata;
endmodule

// File: tb/tb_reg_write_bank.sv
// tb_reg_write_bank: directed vectors with hand-computed expectations for reg_write_bank.
module tb_reg_write_bank;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  write_en;
   logic [15:0] busOut, alu_out;
   logic [3:0]  inc_en, clr_en;
   logic        alu_we;
   logic [7:0]  ir, tr, dr, rn, rp, rc, rr, rcol1, rcol2, dram_wdata;
   logic [15:0] ra, rb, ro, rt, ac;
   logic        dram_we;
   int          errors = 0;
   int          checks = 0;

   reg_write_bank dut (
      .clk(clk), .rst_n(rst_n), .write_en(write_en), .busOut(busOut),
      .inc_en(inc_en), .clr_en(clr_en), .alu_we(alu_we), .alu_out(alu_out),
      .ir(ir), .tr(tr), .dr(dr), .rn(rn), .rp(rp), .rc(rc), .rr(rr),
      .rcol1(rcol1), .rcol2(rcol2), .ra(ra), .rb(rb), .ro(ro), .rt(rt), .ac(ac),
      .dram_we(dram_we), .dram_wdata(dram_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [4:0] w, input logic [15:0] b, input logic [3:0] i = 4'h0,
                      input logic [3:0] c = 4'h0, input logic a = 1'b0, input logic [15:0] ao = 16'h0);
      write_en = w;
      busOut = b;
      inc_en = i;
      clr_en = c;
      alu_we = a;
      alu_out = ao;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero();
      chk("rst_ir", 16'(ir), 0); chk("rst_tr", 16'(tr), 0); chk("rst_dr", 16'(dr), 0);
      chk("rst_rn", 16'(rn), 0); chk("rst_rp", 16'(rp), 0); chk("rst_rc", 16'(rc), 0);
      chk("rst_rr", 16'(rr), 0); chk("rst_rcol1", 16'(rcol1), 0); chk("rst_rcol2", 16'(rcol2), 0);
      chk("rst_ra", ra, 0); chk("rst_rb", rb, 0); chk("rst_ro", ro, 0);
      chk("rst_rt", rt, 0); chk("rst_ac", ac, 0);
      chk("rst_dram_we", 16'(dram_we), 0); chk("rst_dram_wdata", 16'(dram_wdata), 0);
   endtask

   initial begin
      logic [4:0] codes [14] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd12, 5'd16, 5'd17};
      rst_n = 1'b0;
      write_en = '0; busOut = '0; inc_en = '0; clr_en = '0; alu_we = 1'b0; alu_out = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero();
      rst_n = 1'b1;
      // fill every register with a distinct nonzero value, then raise a dram pulse
      foreach (codes[k]) cyc(codes[k], 16'hA000 | 16'(codes[k]));
      chk("map_ir", 16'(ir), 16'h01); chk("map_tr", 16'(tr), 16'h02); chk("map_dr", 16'(dr), 16'h03);
      chk("map_ra", ra, 16'hA004); chk("map_rb", rb, 16'hA005); chk("map_ro", ro, 16'hA006);
      chk("map_rn", 16'(rn), 16'h07); chk("map_rp", 16'(rp), 16'h08); chk("map_rc", 16'(rc), 16'h09);
      chk("map_rr", 16'(rr), 16'h0A); chk("map_rt", rt, 16'hA00B); chk("map_ac", ac, 16'hA00C);
      chk("map_rcol1", 16'(rcol1), 16'h10); chk("map_rcol2", 16'(rcol2), 16'h11);
      cyc(5'd13, 16'h00C3);
      chk("pre_rst_dram_we", 16'(dram_we), 16'h1);
      write_en = 5'd0;
      #3 rst_n = 1'b0;
      #1 chk_zero();
      #1 rst_n = 1'b1;
      cyc(5'd4, 16'hBEEF);
      chk("post_rst_ra", ra, 16'hBEEF);
      chk("post_rst_dram_we", 16'(dram_we), 16'h0);
      // width and split
      cyc(5'd1, 16'h12AB);
      chk("ir_low_byte", 16'(ir), 16'h00AB);
      cyc(5'd14, 16'h5A3C);
      chk("split_ir", 16'(ir), 16'h005A);
      chk("split_tr", 16'(tr), 16'h003C);
      cyc(5'd12, 16'h1234);
      chk("ac_load", ac, 16'h1234);
      cyc(5'd15, 16'h0077);
      chk("ac_high", ac, 16'h7734);
      // increment wrap and priority
      cyc(5'd8, 16'h00FF);
      cyc(5'd0, 16'h0000, 4'b0001);
      chk("rp_wrap", 16'(rp), 16'h0000);
      cyc(5'd9, 16'h0005);
      cyc(5'd9, 16'h0020, 4'b0010);
      chk("rc_write_over_inc", 16'(rc), 16'h0020);
      cyc(5'd9, 16'h0005);
      cyc(5'd9, 16'h0020, 4'b0010, 4'b0010);
      chk("rc_clr_over_write", 16'(rc), 16'h0000);
      // dram strobe train
      write_en = 5'd13; busOut = 16'h0011;
      #2 chk("dram_idle", 16'(dram_we), 16'h0);
      cyc(5'd13, 16'h0011);
      chk("dram_we1", 16'(dram_we), 16'h1); chk("dram_wd1", 16'(dram_wdata), 16'h11);
      cyc(5'd13, 16'h0022);
      chk("dram_we2", 16'(dram_we), 16'h1); chk("dram_wd2", 16'(dram_wdata), 16'h22);
      cyc(5'd13, 16'h0033);
      chk("dram_we3", 16'(dram_we), 16'h1); chk("dram_wd3", 16'(dram_wdata), 16'h33);
      cyc(5'd0, 16'h0044);
      chk("dram_we_off", 16'(dram_we), 16'h0); chk("dram_wd_hold", 16'(dram_wdata), 16'h33);
      chk("dram_ac_kept", ac, 16'h7734); chk("dram_ra_kept", ra, 16'hBEEF);
      chk("dram_ir_kept", 16'(ir), 16'h005A);
      // accumulator conflict
      cyc(5'd12, 16'h00AA, 4'h0, 4'h0, 1'b1, 16'h0F0F);
      chk("ac_bus_over_alu", ac, 16'h00AA);
      cyc(5'd0, 16'h0000, 4'h0, 4'h0, 1'b1, 16'h0F0F);
      chk("ac_alu", ac, 16'h0F0F);
      // concurrency
      cyc(5'd10, 16'h0044);
      cyc(5'd7, 16'h0009, 4'b0001, 4'b0100);
      chk("conc_rn", 16'(rn), 16'h0009); chk("conc_rp", 16'(rp), 16'h0001);
      chk("conc_rr", 16'(rr), 16'h0000); chk("conc_rc", 16'(rc), 16'h0000);
      chk("conc_tr", 16'(tr), 16'h003C); chk("conc_ac", ac, 16'h0F0F);
      cyc(5'd0, 16'h0000, 4'b1111);
      chk("inc_all_rp", 16'(rp), 16'h0002); chk("inc_all_rc", 16'(rc), 16'h0001);
      chk("inc_all_rr", 16'(rr), 16'h0001); chk("inc_all_rn", 16'(rn), 16'h000A);
      cyc(5'd0, 16'h0000, 4'b0000, 4'b1111);
      chk("clr_all_rn", 16'(rn), 16'h0000); chk("clr_all_rp", 16'(rp), 16'h0000);
      // idle code holds everything
      repeat (5) cyc(5'd20, 16'hFFFF);
      chk("idle_ir", 16'(ir), 16'h005A); chk("idle_tr", 16'(tr), 16'h003C);
      chk("idle_ra", ra, 16'hBEEF); chk("idle_ac", ac, 16'h0F0F);
      chk("idle_rr", 16'(rr), 16'h0000); chk("idle_rcol1", 16'(rcol1), 16'h0000);
      chk("idle_dram_we", 16'(dram_we), 16'h0); chk("idle_dram_wd", 16'(dram_wdata), 16'h33);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
